// File: rtl/uart_tx_fifo_drain.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_drain
//   Drains a first-word-fall-through byte FIFO onto a UART transmit pin.
//   Each popped word goes out as: start bit, WordLength data bits LSB first,
//   optional even-parity bit, one stop bit. Frames run back-to-back while the
//   FIFO has data and en_i is high.
//
//   Optional feature macro: UART_TX_PARITY_EN (adds the even-parity bit).
//
// Parameters
//   WordLength  data bits per frame (matches FIFO word width)
//   ClksPerBit  clk_i cycles per serial bit, 2..65535
//
// Ports
//   clk_i         system clock, rising edge
//   rst_i         asynchronous active-high reset
//   en_i          allows new frames to start (never aborts one in flight)
//   fifo_empty_i  FIFO empty flag
//   fifo_data_i   FIFO head word, valid while fifo_empty_i=0
//   fifo_rd_o     FIFO pop strobe, one cycle per word
//   tx_o          serial output, idle high
//   busy_o        high for every START..STOP cycle
//   done_tick_o   one-cycle pulse on the last STOP cycle
// ---------------------------------------------------------------------------
module uart_tx_fifo_drain #(
  parameter int WordLength = 8,
  parameter int ClksPerBit = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  fifo_empty_i,
  input  logic [WordLength-1:0] fifo_data_i,
  output logic                  fifo_rd_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_tick_o
);

  localparam int BaudW = $clog2(ClksPerBit);
  localparam int BitW  = (WordLength > 1) ? $clog2(WordLength) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);
  localparam logic [BaudW-1:0] BaudPen  = BaudW'(ClksPerBit - 2);
  localparam logic [BitW-1:0]  BitLast  = BitW'(WordLength - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                r_state;
  logic [BaudW-1:0]      r_baud;
  logic [BitW-1:0]       r_bit;
  logic [WordLength-1:0] r_shreg;
`ifdef UART_TX_PARITY_EN
  logic                  r_par;
`endif
  logic                  r_rd;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_baud_last;
  logic                  w_load;
  logic [WordLength-1:0] w_shift;

  assign w_baud_last = (r_baud == BaudLast);
  assign w_shift     = r_shreg >> 1;
  // Pop from IDLE, or on the last STOP cycle so the next START follows with no gap.
  assign w_load      = en_i && !fifo_empty_i &&
                       ((r_state == IDLE) || ((r_state == STOP) && w_baud_last));

  // Outputs are registered: tx/busy are written with the value of the state
  // being entered, so they line up with r_state rather than lagging it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
      r_rd    <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_rd   <= 1'b0;
      r_done <= 1'b0;
      r_baud <= ((r_state == IDLE) || w_baud_last) ? '0 : r_baud + BaudW'(1);

      unique case (r_state)
        IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
        end
        START: begin
          if (w_baud_last) begin
            r_state <= DATA;
            r_bit   <= '0;
            r_tx    <= r_shreg[0];
          end
        end
        DATA: begin
          if (w_baud_last) begin
            if (r_bit == BitLast) begin
`ifdef UART_TX_PARITY_EN
              r_state <= PARITY;
              r_tx    <= r_par;
`else
              r_state <= STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit   <= r_bit + BitW'(1);
              r_shreg <= w_shift;
              r_tx    <= w_shift[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_baud_last) begin
            r_state <= STOP;
            r_tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          // Registered pulse must land on the final STOP cycle.
          if (r_baud == BaudPen) r_done <= 1'b1;
          if (w_baud_last) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase

      // Load overrides the IDLE/STOP exit above; data is captured only here.
      if (w_load) begin
        r_state <= START;
        r_shreg <= fifo_data_i;
`ifdef UART_TX_PARITY_EN
        r_par   <= ^fifo_data_i;
`endif
        r_rd    <= 1'b1;
        r_tx    <= 1'b0;
        r_busy  <= 1'b1;
      end
    end
  end

  assign fifo_rd_o   = r_rd;
  assign tx_o        = r_tx;
  assign busy_o      = r_busy;
  assign done_tick_o = r_done;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
module tb_uart_tx_fifo_drain;
  localparam int WL = 8;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NBITS = WL + 2 + PB;
  localparam int FRAME = NBITS * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [WL-1:0] fifo_data  = '0;
  logic          rd, tx, busy, done;

  always #5 clk = ~clk;

  uart_tx_fifo_drain #(.WordLength(WL), .ClksPerBit(CPB)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
    .fifo_rd_o(rd), .tx_o(tx), .busy_o(busy), .done_tick_o(done)
  );

  logic [WL-1:0] fq[$];     // FIFO model contents
  logic [WL-1:0] exp_q[$];  // scoreboard: words expected on the wire, in order
  logic          wav[$];    // tx samples of the frame being received

  int errs = 0, checks = 0;
  int cyc = 0, pops = 0, last_pop = -1000, pop_gap = 0;
  int ndone = 0, run = 0, last_run = 0;

  // FWFT FIFO model: pop on rd, flags update after the edge.
  always @(posedge clk) begin
    if (rd && fq.size() > 0) fq.delete(0);
    fifo_empty <= (fq.size() == 0);
    fifo_data  <= (fq.size() > 0) ? fq[0] : '0;
  end

  function automatic logic [NBITS-1:0] frame_bits(input logic [WL-1:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  task automatic check_frame();
    logic [WL-1:0]    eb;
    logic [NBITS-1:0] e, got;
    bit bad;
    checks++;
    if (exp_q.size() == 0) begin
      errs++;
      $display("FAIL frame: got unexpected frame len=%0d, required none", wav.size());
      return;
    end
    eb  = exp_q.pop_front();
    e   = frame_bits(eb);
    got = '0;
    bad = (wav.size() != FRAME);
    for (int k = 0; k < NBITS; k++) begin
      if (k * CPB + CPB - 1 < wav.size()) begin
        got[k] = wav[k * CPB + CPB / 2];
        for (int j = 0; j < CPB; j++)
          if (wav[k * CPB + j] !== e[k]) bad = 1;
      end else bad = 1;
    end
    if (bad) begin
      errs++;
      $display("FAIL frame %h: got len=%0d bits=%b, required len=%0d bits=%b",
               eb, wav.size(), got, FRAME, e);
    end
  endtask

  // Monitor: decodes frames on tx and checks them against the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      wav.delete();
      run = 0;
    end else begin
      if (rd) begin
        checks++;
        if (fifo_empty) begin
          errs++;
          $display("FAIL rd_while_empty: got rd=1 with empty=1, required rd=0");
        end
        pops++;
        pop_gap  = cyc - last_pop;
        last_pop = cyc;
      end
      if (busy) begin
        run++;
        wav.push_back(tx);
      end else if (run > 0) begin
        last_run = run;
        run = 0;
      end
      if (done) begin
        ndone++;
        check_frame();
        wav.delete();
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input logic [WL-1:0] b, input bit expect_it);
    fq.push_back(b);
    if (expect_it) exp_q.push_back(b);
  endtask

  task automatic wait_quiet(input int lim);
    int q = 0, n = 0;
    while (q < 3 && n < lim) begin
      @(negedge clk);
      n++;
      if (!busy && (fq.size() == 0 || !en)) q++; else q = 0;
    end
    if (q < 3) chk("wait_quiet_timeout", n, -1);
    #1;
  endtask

  task automatic wait_busy(input int lim);
    int n = 0;
    while (!busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!busy) chk("wait_busy_timeout", n, -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    int p0, d0;
    bit bad;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd", int'(rd), 0);
    chk("rst_done", int'(done), 0);
    #1 rst = 1'b0;
    en = 1'b1;

    // 1: single 0xA5 frame
    p0 = pops; d0 = ndone;
    push(8'hA5, 1);
    wait_quiet(500);
    chk("t1_pops", pops - p0, 1);
    chk("t1_done", ndone - d0, 1);
    chk("t1_busy_len", last_run, FRAME);

    // 2: 0x00 then 0xFF back-to-back
    p0 = pops; d0 = ndone;
    push(8'h00, 1);
    push(8'hFF, 1);
    wait_quiet(500);
    chk("t2_pops", pops - p0, 2);
    chk("t2_pop_gap", pop_gap, FRAME);
    chk("t2_done", ndone - d0, 2);
    chk("t2_busy_len", last_run, 2 * FRAME);

    // 3: empty FIFO, enabled, 200 cycles
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || rd !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    chk("t3_idle_empty", int'(bad), 0);

    // 4: en dropped at cycle 10 of a 0x3C frame with 0x55 queued
    #1 p0 = pops;
    push(8'h3C, 1);
    push(8'h55, 0);
    wait_busy(50);
    repeat (9) @(negedge clk);
    #1 en = 1'b0;
    wait_quiet(500);
    chk("t4_pops", pops - p0, 1);
    chk("t4_busy_len", last_run, FRAME);
    chk("t4_fifo_left", fq.size(), 1);
    repeat (20) @(negedge clk);
    chk("t4_stay_idle", int'(busy), 0);
    fq.delete();
    repeat (3) @(negedge clk);
    #1 en = 1'b1;

    // 5: reset at cycle 17 of a frame; next word restarts cleanly
    p0 = pops;
    push(8'h11, 0);
    push(8'h22, 1);
    wait_busy(50);
    repeat (16) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5_async_tx", int'(tx), 1);
    chk("t5_async_busy", int'(busy), 0);
    chk("t5_async_rd", int'(rd), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    wait_quiet(500);
    chk("t5_pops", pops - p0, 2);
    chk("t5_busy_len", last_run, FRAME);

    // 6: 0xA5 (even parity 0) and 0x07 (even parity 1)
    p0 = pops;
    push(8'hA5, 1);
    push(8'h07, 1);
    wait_quiet(500);
    chk("t6_pops", pops - p0, 2);
    chk("t6_busy_len", last_run, 2 * FRAME);

    chk("leftover_expected", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
